// File: rtl/axi_pkg.sv
// Shared AXI3 constants, FSM state types and the request bundle
// used by the SRAM slave and its burst address helper.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_req_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts at word granularity.
// Illegal WRAP lengths and the reserved burst type fall back to INCR.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_o
);

    logic [31:0] inc;
    logic [31:0] mask;
    logic        is_fixed;
    logic        is_wrap;
    logic        unused_size;

    // Every beat moves one 32-bit word regardless of size
    assign unused_size = ^size_i;

    always_comb begin
        inc      = addr_i + 32'd4;
        mask     = ({24'd0, len_i} << 2) | 32'd3;
        is_fixed = (burst_i == BURST_FIXED);
        is_wrap  = (burst_i == BURST_WRAP)
                 && (len_i == 8'd1 || len_i == 8'd3
                  || len_i == 8'd7 || len_i == 8'd15);
        next_o   = inc;
        unique case (1'b1)
            is_fixed: next_o = addr_i;
            is_wrap:  next_o = (addr_i & ~mask) | (inc & mask);
            default:  next_o = inc;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-wide SRAM with one read and one
// byte-enabled write port; read and write channels run independently.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int    MEM_AW    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    logic unused_in;
    assign unused_in = ^{arlock, arcache, arprot,
                         awlock, awcache, awprot, wid};

    // ---------------- read channel ----------------
    rd_state_t   rd_state_q;
    axi_req_t    rd_req_q;
    logic [7:0]  rd_cnt_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] rd_next;
    logic        ar_err;
    logic        rd_err;

    axi_burst_addr u_rd_addr (
        .addr_i  (rd_req_q.addr),
        .len_i   (rd_req_q.len),
        .size_i  (rd_req_q.size),
        .burst_i (rd_req_q.burst),
        .next_o  (rd_next)
    );

    assign ar_err = (arsize > 3'd2);
    assign rd_err = (rd_req_q.size > 3'd2);

    // Data is fetched on the edge that opens each beat, so a
    // same-cycle write to that word is seen only by later beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rd_req_q   <= '0;
            rd_cnt_q   <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            unique case (rd_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        rd_req_q   <= '{id: arid, addr: araddr,
                                        len: arlen, size: arsize,
                                        burst: arburst};
                        rd_cnt_q   <= '0;
                        rvalid_q   <= 1'b1;
                        rlast_q    <= (arlen == 8'd0);
                        rresp_q    <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_q    <= ar_err ? '0
                                      : mem[araddr[MEM_AW+1:2]];
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_cnt_q      <= rd_cnt_q + 8'd1;
                            rd_req_q.addr <= rd_next;
                            rlast_q       <= (rd_cnt_q + 8'd1
                                              == rd_req_q.len);
                            rdata_q       <= rd_err ? '0
                                             : mem[rd_next[MEM_AW+1:2]];
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign arready = (rd_state_q == R_IDLE);
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = rd_req_q.id;

    // ---------------- write channel ----------------
    wr_state_t   wr_state_q;
    axi_req_t    wr_req_q;
    logic [7:0]  wr_cnt_q;
    logic        werr_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [31:0] wr_next;
    logic        w_last_beat;
    logic        w_fire;
    logic        mem_we;

    axi_burst_addr u_wr_addr (
        .addr_i  (wr_req_q.addr),
        .len_i   (wr_req_q.len),
        .size_i  (wr_req_q.size),
        .burst_i (wr_req_q.burst),
        .next_o  (wr_next)
    );

    assign w_last_beat = (wr_cnt_q == wr_req_q.len);
    assign w_fire      = (wr_state_q == W_DATA) && wvalid;
    assign mem_we      = w_fire && (wr_req_q.size <= 3'd2);

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[wr_req_q.addr[MEM_AW+1:2]][8*b +: 8]
                        <= wdata[8*b +: 8];
            end
        end
    end

    // Burst length always comes from len; a wlast mismatch only taints bresp
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            wr_req_q   <= '0;
            wr_cnt_q   <= '0;
            werr_q     <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (awvalid) begin
                        wr_req_q   <= '{id: awid, addr: awaddr,
                                        len: awlen, size: awsize,
                                        burst: awburst};
                        wr_cnt_q   <= '0;
                        werr_q     <= (awsize > 3'd2);
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        if (w_last_beat) begin
                            bresp_q    <= (werr_q || !wlast)
                                          ? RESP_SLVERR : RESP_OKAY;
                            bvalid_q   <= 1'b1;
                            wr_state_q <= W_RESP;
                        end else begin
                            wr_cnt_q      <= wr_cnt_q + 8'd1;
                            wr_req_q.addr <= wr_next;
                            werr_q        <= werr_q | wlast;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign awready = (wr_state_q == W_IDLE);
    assign wready  = (wr_state_q == W_DATA);
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = wr_req_q.id;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed AXI bursts push expected
// R/B responses into queues that a negedge monitor pops and compares.
module tb_axi_sram_slave;

    localparam logic [1:0] FIX  = 2'b00;
    localparam logic [1:0] INC  = 2'b01;
    localparam logic [1:0] WRP  = 2'b10;
    localparam int         TMO  = 100;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    always #5 aclk = ~aclk;

    axi_sram_slave dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arlock  (2'b00),
        .arcache (4'b0000),
        .arprot  (3'b000),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awlock  (2'b00),
        .awcache (4'b0000),
        .awprot  (3'b000),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (4'd0),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    logic [38:0] rq[$];
    logic [5:0]  bq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        bp_en = 1'b0;
    logic [31:0] wd[16];
    logic [3:0]  ws[16];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic void push_r(logic [3:0] id, logic [31:0] d,
                                   logic [1:0] resp, logic last);
        rq.push_back({id, d, resp, last});
    endfunction

    function automatic void push_b(logic [3:0] id, logic [1:0] resp);
        bq.push_back({id, resp});
    endfunction

    // Monitor: peeks while stalled (checks stability), pops on handshake
    initial forever begin
        @(negedge aclk);
        if (aresetn) begin
            if (rvalid) begin
                if (rq.size() == 0) begin
                    timeout("r_unexpected");
                end else begin
                    chk("r_beat", 64'({rid, rdata, rresp, rlast}),
                        64'(rq[0]));
                    if (rready) void'(rq.pop_front());
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) begin
                    timeout("b_unexpected");
                end else begin
                    chk("b_resp", 64'({bid, bresp}), 64'(bq[0]));
                    if (bready) void'(bq.pop_front());
                end
            end
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (bp_en) rready = 1'($urandom_range(0, 1));
    end

    task automatic rd(logic [3:0] id, logic [31:0] a, logic [7:0] len,
                      logic [2:0] size, logic [1:0] burst);
        int t;
        @(posedge aclk);
        #1;
        arid = id; araddr = a; arlen = len;
        arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!arready && t < TMO) begin
            @(negedge aclk);
            t++;
        end
        if (t >= TMO) timeout("ar_wait");
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        chk("r_latency", 64'(rvalid), 64'd1);
    endtask

    task automatic wr(logic [3:0] id, logic [31:0] a, logic [7:0] len,
                      logic [2:0] size, logic [1:0] burst, int wlast_at);
        int t;
        @(posedge aclk);
        #1;
        awid = id; awaddr = a; awlen = len;
        awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!awready && t < TMO) begin
            @(negedge aclk);
            t++;
        end
        if (t >= TMO) timeout("aw_wait");
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        chk("w_ready_lat", 64'(wready), 64'd1);
        chk("aw_busy", 64'(awready), 64'd0);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == wlast_at);
            t = 0;
            @(negedge aclk);
            while (!wready && t < TMO) begin
                @(negedge aclk);
                t++;
            end
            if (t >= TMO) timeout("w_wait");
            @(posedge aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("b_latency", 64'(bvalid), 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 4 * TMO) begin
            @(negedge aclk);
            t++;
        end
        chk("queues_empty", 64'(rq.size() + bq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ws[i] = 4'hF;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rfields", 64'({rid, rdata, rresp}), 64'd0);
        chk("rst_bfields", 64'({bid, bresp}), 64'd0);
        aresetn = 1'b1;

        // single read of a preloaded word
        wd[0] = 32'hDEADBEEF;
        push_b(4'd1, 2'b00);
        wr(4'd1, 32'h100, 8'd0, 3'd2, INC, 0);
        drain();
        push_r(4'd3, 32'hDEADBEEF, 2'b00, 1'b1);
        rd(4'd3, 32'h100, 8'd0, 3'd2, INC);
        drain();

        // INCR write and read back
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        push_b(4'd2, 2'b00);
        wr(4'd2, 32'h200, 8'd3, 3'd2, INC, 3);
        for (int i = 0; i < 4; i++)
            push_r(4'd5, 32'(i + 1), 2'b00, i == 3);
        rd(4'd5, 32'h200, 8'd3, 3'd2, INC);
        drain();

        // WRAP read starting mid-window
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        push_b(4'd6, 2'b00);
        wr(4'd6, 32'h300, 8'd3, 3'd2, INC, 3);
        push_r(4'd7, 32'hA3, 2'b00, 1'b0);
        push_r(4'd7, 32'hA0, 2'b00, 1'b0);
        push_r(4'd7, 32'hA1, 2'b00, 1'b0);
        push_r(4'd7, 32'hA2, 2'b00, 1'b1);
        rd(4'd7, 32'h30C, 8'd3, 3'd2, WRP);
        drain();

        // FIXED read repeats the same word
        push_r(4'd8, 32'h3, 2'b00, 1'b0);
        push_r(4'd8, 32'h3, 2'b00, 1'b1);
        rd(4'd8, 32'h208, 8'd1, 3'd2, FIX);
        drain();

        // random back-pressure
        bp_en = 1'b1;
        for (int i = 0; i < 4; i++)
            push_r(4'd9, 32'(i + 1), 2'b00, i == 3);
        rd(4'd9, 32'h200, 8'd3, 3'd2, INC);
        push_r(4'd10, 32'hA2, 2'b00, 1'b0);
        push_r(4'd10, 32'hA3, 2'b00, 1'b0);
        push_r(4'd10, 32'hA0, 2'b00, 1'b0);
        push_r(4'd10, 32'hA1, 2'b00, 1'b1);
        rd(4'd10, 32'h308, 8'd3, 3'd2, WRP);
        drain();
        bp_en = 1'b0;
        @(posedge aclk);
        #2;
        rready = 1'b1;

        // byte strobes
        wd[0] = 32'hFFFFFFFF;
        push_b(4'd11, 2'b00);
        wr(4'd11, 32'h400, 8'd0, 3'd2, INC, 0);
        wd[0] = 32'h11223344;
        ws[0] = 4'b0101;
        push_b(4'd12, 2'b00);
        wr(4'd12, 32'h400, 8'd0, 3'd2, INC, 0);
        ws[0] = 4'hF;
        push_r(4'd13, 32'hFF22FF44, 2'b00, 1'b1);
        rd(4'd13, 32'h400, 8'd0, 3'd2, INC);
        drain();

        // error responses
        wd[0] = 32'h55; wd[1] = 32'h66;
        push_b(4'd4, 2'b10);
        wr(4'd4, 32'h500, 8'd1, 3'd2, INC, 0);
        wd[0] = 32'h0;
        push_b(4'd5, 2'b10);
        wr(4'd5, 32'h400, 8'd0, 3'd3, INC, 0);
        push_r(4'd14, 32'hFF22FF44, 2'b00, 1'b1);
        rd(4'd14, 32'h400, 8'd0, 3'd2, INC);
        push_r(4'd6, 32'h0, 2'b10, 1'b0);
        push_r(4'd6, 32'h0, 2'b10, 1'b1);
        rd(4'd6, 32'h200, 8'd1, 3'd3, INC);
        drain();

        // reset during beat 2 of a len-7 read
        for (int i = 0; i < 8; i++) wd[i] = 32'h60 + 32'(i);
        push_b(4'd7, 2'b00);
        wr(4'd7, 32'h600, 8'd7, 3'd2, INC, 7);
        drain();
        push_r(4'd9, 32'h60, 2'b00, 1'b0);
        push_r(4'd9, 32'h61, 2'b00, 1'b0);
        rd(4'd9, 32'h600, 8'd7, 3'd2, INC);
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        chk("pre_rst_beat2", 64'({rvalid, rdata}), 64'({1'b1, 32'h62}));
        aresetn = 1'b0;
        #1;
        chk("async_rst_rvalid", 64'(rvalid), 64'd0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_arready", 64'(arready), 64'd1);
        chk("post_rst_awready", 64'(awready), 64'd1);
        push_r(4'd10, 32'h62, 2'b00, 1'b0);
        push_r(4'd10, 32'h63, 2'b00, 1'b1);
        rd(4'd10, 32'h608, 8'd1, 3'd2, INC);
        push_r(4'd11, 32'hDEADBEEF, 2'b00, 1'b1);
        rd(4'd11, 32'h100, 8'd0, 3'd2, INC);
        drain();

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
